// File: rtl/ca_pkg.sv
// ca_pkg
// Shared constants and types for the elementary-CA scheduler and cell datapath.
//   HEIGHT, LOG_CELL_SIZE, CELL_SIZE : frame geometry shared with the datapath
//   NUM_RULES, IDX_W, BAND_LOG, RC_W : rule table depth and row-counter layout
//   rule_t, rule_idx_t              : Wolfram rule number and table index
//   seed_state_t                    : seed FSM states
//   DEFAULT_RULES                   : reset contents of both rule banks
package ca_pkg;

    localparam int HEIGHT        = 480;
    localparam int LOG_CELL_SIZE = 2;
    localparam int CELL_SIZE     = 1 << LOG_CELL_SIZE;
    localparam int NUM_RULES     = 8;
    localparam int IDX_W         = $clog2(NUM_RULES);
    localparam int BAND_LOG      = 8;
    localparam int RC_W          = BAND_LOG + IDX_W;

    typedef logic [7:0]       rule_t;
    typedef logic [IDX_W-1:0] rule_idx_t;

    typedef enum logic [1:0] {
        ST_SEED      = 2'd0,
        ST_RUN       = 2'd1,
        ST_SEED_PEND = 2'd2
    } seed_state_t;

    // Packed so entry i sits at [i]; entry 0 is the rightmost element.
    localparam logic [NUM_RULES-1:0][7:0] DEFAULT_RULES = {
        8'd102, 8'd105, 8'd146, 8'd90, 8'd73, 8'd22, 8'd110, 8'd30
    };

endpackage

// File: rtl/ca_rule_scheduler_if.sv
// ca_rule_scheduler_if
// Bundles the line timing, host rule-write handshake and per-row control
// outputs of the CA scheduler.
//   master : line timing / host side (drives line_start, pix_y, auto_en,
//            seed_req, cfg_valid/addr/data)
//   slave  : the scheduler (drives cfg_ready and all row outputs)
interface ca_rule_scheduler_if;
    import ca_pkg::*;

    logic        line_start;
    logic [9:0]  pix_y;
    logic        auto_en;
    logic        seed_req;
    logic        cfg_valid;
    logic        cfg_ready;
    rule_idx_t   cfg_addr;
    rule_t       cfg_data;
    rule_t       rule;
    rule_idx_t   rule_idx;
    logic        copy_row;
    logic        load_row;
    logic        capture_row;
    logic        seed_active;
    logic        frame_tick;
    logic [7:0]  frame_count;

    modport master (
        output line_start, pix_y, auto_en, seed_req, cfg_valid, cfg_addr, cfg_data,
        input  cfg_ready, rule, rule_idx, copy_row, load_row, capture_row,
               seed_active, frame_tick, frame_count
    );

    modport slave (
        input  line_start, pix_y, auto_en, seed_req, cfg_valid, cfg_addr, cfg_data,
        output cfg_ready, rule, rule_idx, copy_row, load_row, capture_row,
               seed_active, frame_tick, frame_count
    );

endinterface

// File: rtl/ca_rule_table.sv
// ca_rule_table
// Dual-bank rule register file. Host writes land in the shadow bank; the
// commit strobe copies the whole shadow bank into the active bank, which is
// the only bank the datapath ever reads.
//   clk, reset  : clock, async active-high reset (both banks -> defaults)
//   wr_en_i     : shadow write strobe
//   wr_addr_i   : shadow entry to write
//   wr_data_i   : rule number to write
//   commit_i    : copy shadow -> active
//   rd_idx_i    : active-bank read index
//   rd_rule_o   : active-bank read data
module ca_rule_table
    import ca_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en_i,
    input  rule_idx_t wr_addr_i,
    input  rule_t     wr_data_i,
    input  logic      commit_i,
    input  rule_idx_t rd_idx_i,
    output rule_t     rd_rule_o
);

    logic [NUM_RULES-1:0][7:0] shadow_q;
    logic [NUM_RULES-1:0][7:0] active_q;

    // The scheduler never writes in a commit cycle; if both ever coincided the
    // active bank would take the pre-write shadow contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= DEFAULT_RULES;
            active_q <= DEFAULT_RULES;
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            if (commit_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign rd_rule_o = active_q[rd_idx_i];

endmodule

// File: rtl/ca_rule_scheduler.sv
// ca_rule_scheduler
// Per-row sequencing for the elementary-CA datapath: picks the rule band for
// each cell row, flags seed/load/copy/capture rows, scrolls one cell row per
// frame when enabled, and commits host rule writes only at frame end.
//   clk, reset : pixel clock, async active-high reset
//   sched_if   : slave side of ca_rule_scheduler_if (line timing in, host
//                rule-write handshake, registered row outputs)
//
// Seed FSM
//   state        | meaning
//   ST_SEED      | row 0 uses the single-centre-cell seed; leaves at capture line
//   ST_RUN       | normal evolution; a seed request arms a reseed
//   ST_SEED_PEND | reseed armed; at frame end row_count clears and SEED resumes
module ca_rule_scheduler
    import ca_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    ca_rule_scheduler_if.slave   sched_if
);

    localparam logic [9:0]      HEIGHT_Y       = 10'(HEIGHT);
    localparam logic [9:0]      CELL_Y         = 10'(CELL_SIZE);
    localparam logic [RC_W-1:0] ROWS_PER_FRAME = RC_W'(HEIGHT >> LOG_CELL_SIZE);

    seed_state_t     state_q, state_d;
    logic [RC_W-1:0] row_count_q, row_count_d;
    rule_idx_t       rule_idx_q;
    logic            copy_q, copy_d;
    logic            load_q, load_d;
    logic            capture_q, capture_d;
    logic            seed_q, seed_d;
    logic            tick_q, tick_d;
    logic [7:0]      fcount_q, fcount_d;
    logic            ready_q;

    logic            line_start;
    logic            frame_end;
    logic            cfg_wr;
    rule_t           rule_rd;

    assign line_start = sched_if.line_start;
    assign frame_end  = line_start && (sched_if.pix_y == HEIGHT_Y);

    // Blocking writes in the commit cycle keeps shadow and commit disjoint.
    assign sched_if.cfg_ready = ready_q && !frame_end;
    assign cfg_wr             = sched_if.cfg_valid && sched_if.cfg_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEED;
            row_count_q <= '0;
            rule_idx_q  <= '0;
            copy_q      <= 1'b0;
            load_q      <= 1'b0;
            capture_q   <= 1'b0;
            seed_q      <= 1'b1;
            tick_q      <= 1'b0;
            fcount_q    <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            rule_idx_q  <= row_count_d[RC_W-1:BAND_LOG];
            copy_q      <= copy_d;
            load_q      <= load_d;
            capture_q   <= capture_d;
            seed_q      <= seed_d;
            tick_q      <= tick_d;
            fcount_q    <= fcount_d;
            ready_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        copy_d      = copy_q;
        load_d      = load_q;
        capture_d   = capture_q;
        seed_d      = seed_q;
        tick_d      = 1'b0;
        fcount_d    = fcount_q;

        if (line_start) begin
            // Blanking lines (pix_y > HEIGHT) fall through with all flags low.
            copy_d    = 1'b0;
            load_d    = 1'b0;
            capture_d = 1'b0;
            seed_d    = 1'b0;

            if (sched_if.pix_y < HEIGHT_Y) begin
                copy_d = (sched_if.pix_y[LOG_CELL_SIZE-1:0] != '0);
                if (sched_if.pix_y[LOG_CELL_SIZE-1:0] == '0) begin
                    row_count_d = row_count_q + RC_W'(1);
                end
            end

            if (sched_if.pix_y <= HEIGHT_Y) begin
                load_d    = (sched_if.pix_y == '0) && (state_q != ST_SEED);
                capture_d = (sched_if.pix_y == CELL_Y);
                seed_d    = (state_q == ST_SEED);
            end

            // Undo the frame's row advance, keeping one row of scroll if enabled.
            if (frame_end) begin
                tick_d      = 1'b1;
                fcount_d    = fcount_q + 8'd1;
                row_count_d = row_count_q + RC_W'(sched_if.auto_en) - ROWS_PER_FRAME;
            end
        end

        unique case (state_q)
            ST_SEED: begin
                if (line_start && (sched_if.pix_y == CELL_Y)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sched_if.seed_req) begin
                    state_d = ST_SEED_PEND;
                end
            end
            ST_SEED_PEND: begin
                if (frame_end) begin
                    state_d     = ST_SEED;
                    row_count_d = '0;
                end
            end
            default: begin
                state_d = ST_SEED;
            end
        endcase
    end

    ca_rule_table u_rule_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (cfg_wr),
        .wr_addr_i (sched_if.cfg_addr),
        .wr_data_i (sched_if.cfg_data),
        .commit_i  (frame_end),
        .rd_idx_i  (rule_idx_q),
        .rd_rule_o (rule_rd)
    );

    assign sched_if.rule        = rule_rd;
    assign sched_if.rule_idx    = rule_idx_q;
    assign sched_if.copy_row    = copy_q;
    assign sched_if.load_row    = load_q;
    assign sched_if.capture_row = capture_q;
    assign sched_if.seed_active = seed_q;
    assign sched_if.frame_tick  = tick_q;
    assign sched_if.frame_count = fcount_q;

endmodule
